ysyx_23060203_ifu_prefetch: RTL and testbench
=============================================

// Module: ysyx_23060203_ifu_prefetch
// PURPOSE
//  Parametrised instruction-fetch front end; replaces the fixed single-cycle PC/IFU pair.
//  - Issues sequential fetch requests over a valid/ready memory interface.
//  - Tolerates variable and pipelined memory latency, with up to DEPTH requests outstanding.
//  - Buffers returned instructions in a DEPTH-entry queue feeding the IDU.
//  - Supports redirect (branch/jump dnpc) with flush and discard of stale responses.
// PARAMETERS
//  XLEN      32            address/PC width
//  RESET_PC  32'h8000_0000 first fetch address after reset
//  DEPTH     4             queue entries = max outstanding + buffered; power of 2, >=2
// PORTS
//  clk             in   1     clock, rising edge
//  rstn            in   1     asynchronous active-low reset
//  redirect_valid  in   1     load redirect_pc as new fetch stream, flush everything
//  redirect_pc     in   XLEN  redirect target; bits[1:0] ignored (treated 0)
//  imem_req_valid  out  1     fetch request valid
//  imem_req_ready  in   1     memory accepts request
//  imem_req_addr   out  XLEN  fetch address
//  imem_rsp_valid  in   1     response valid; in-order; no backpressure (always accepted)
//  imem_rsp_data   in   32    instruction word
//  imem_rsp_err    in   1     access fault for this response
//  inst_valid      out  1     queue head valid
//  inst_ready      in   1     IDU consumes head
//  inst_pc         out  XLEN  PC of head
//  inst_data       out  32    instruction of head
//  inst_err        out  1     head carries access fault
// BEHAVIOUR
//  Reset (async, rstn=0)
//   - fetch_pc=rsp_pc=RESET_PC; inflight=discard=count=0; halted=0; held_stale=0.
//   - All outputs 0 except imem_req_addr=RESET_PC, inst_pc=RESET_PC.
//  Request side
//   - req_valid = !halted && (inflight+count < DEPTH) && !(redirect_valid && !held).
//   - Once valid and not accepted, valid and addr are held stable ("held") even across a redirect.
//   - On accept: inflight+1, fetch_pc += 4 (wraps modulo 2^XLEN).
//   - First request is visible the first cycle after rstn deasserts.
//  Response side
//   - rsp with discard>0: dropped, discard-1.
//   - Otherwise: pushed {rsp_pc,data,err}, rsp_pc += 4.
//   - Each response: inflight-1.
//   - Credit rule guarantees push never overflows.
//  Error
//   - A kept rsp with err=1 sets halted: no new requests until redirect.
//   - Already-outstanding requests complete normally and are queued.
//  Redirect (cycle R, highest priority)
//   - Next cycle: fetch_pc=rsp_pc=redirect_pc; count=0; halted=0.
//   - discard = inflight + accept_R - rsp_R; a response arriving in R is dropped.
//   - If a request is held unaccepted in R: held_stale=1; on its accept discard+1, held_stale=0.
//   - A pop in R is allowed (head consumed); inst_valid=0 in R+1.
//   - Earliest new-stream request in R+1.
//  Queue
//   - Circular, DEPTH entries, log2(DEPTH)-bit pointers wrap naturally.
//   - count width $clog2(DEPTH+1).
//   - inst_* driven from head register; push to empty queue -> inst_valid next cycle (1-cycle latency).
//   - Push and pop in the same cycle: count unchanged.
//   - inst_* stable while inst_valid && !inst_ready.
// STRUCTURE
//  - Package ysyx_23060203_fetch_pkg: XLEN, RESET_PC defaults, typedef fetch_entry_t {pc,data,err}.
//  - Sub-module ysyx_23060203_fetch_fifo: DEPTH-entry sync FIFO of fetch_entry_t, flush input,
//    count output.
//  - Top: request FSM-less credit logic, fetch_pc/rsp_pc, discard counter, halted, held_stale.
// TESTING
//  1 Reset, mem ready=1, 1-cycle rsp, inst_ready=1
//    -> addrs 8000_0000,..04,..08; inst_pc follows; one inst/cycle steady state.
//  2 inst_ready=0, DEPTH=4
//    -> exactly 4 requests accepted, then req_valid=0.
//    -> release: head PCs 8000_0000..0C in order; req resumes.
//  3 3 outstanding, redirect to 8000_1000
//    -> next 3 responses dropped; first inst_pc=8000_1000; queue empty in R+1.
//  4 req_valid held with ready=0, redirect to 8000_2000, then ready=1
//    -> old addr accepted and discarded; next req addr 8000_2000.
//  5 rsp_err=1 on 8000_0008
//    -> inst_err=1 at that PC; no further requests.
//    -> redirect to 8000_0100 resumes fetch.
//  6 rstn pulsed low mid-stream (async)
//    -> outputs reset immediately; fetch restarts at RESET_PC; no stale inst delivered.

Source files
------------

// File: rtl/ysyx_23060203_fetch_pkg.sv
// ----------------------------------------------------------------------------
// ysyx_23060203_fetch_pkg : shared defaults and queue entry type for the IFU
// Revision: 1.0
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

package ysyx_23060203_fetch_pkg;

  localparam int unsigned DEFAULT_XLEN = 32;
  localparam logic [DEFAULT_XLEN-1:0] DEFAULT_RESET_PC = 32'h8000_0000;

  typedef struct packed {
    logic [DEFAULT_XLEN-1:0] pc;
    logic [31:0]             data;
    logic                    err;
  } fetch_entry_t;

endpackage

`default_nettype wire

// File: rtl/ysyx_23060203_fetch_fifo.sv
// ----------------------------------------------------------------------------
// ysyx_23060203_fetch_fifo : DEPTH-entry circular queue of fetched instructions
// Revision: 1.0
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module ysyx_23060203_fetch_fifo
  import ysyx_23060203_fetch_pkg::*;
#(
  parameter int unsigned                     DEPTH    = 4,
  parameter logic [DEFAULT_XLEN-1:0]         RESET_PC = DEFAULT_RESET_PC
) (
  input  logic                               clk,
  input  logic                               rstn,
  input  logic                               flush_i,
  input  logic                               push_i,
  input  fetch_entry_t                       push_data_i,
  input  logic                               pop_i,
  output fetch_entry_t                       head_o,
  output logic [$clog2(DEPTH+1)-1:0]         count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  fetch_entry_t   mem_q [DEPTH];
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_i)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push_i, pop_i})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Entries reset to RESET_PC so the head reads back RESET_PC out of reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '{pc: RESET_PC, data: 32'h0, err: 1'b0};
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/ysyx_23060203_ifu_prefetch.sv
// ----------------------------------------------------------------------------
// ysyx_23060203_ifu_prefetch : credit-based prefetching fetch front end with redirect
// Revision: 1.0
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module ysyx_23060203_ifu_prefetch
  import ysyx_23060203_fetch_pkg::*;
#(
  parameter int unsigned     XLEN     = DEFAULT_XLEN,
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int unsigned     DEPTH    = 4
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  input  logic            imem_rsp_err,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst_pc,
  output logic [31:0]     inst_data,
  output logic            inst_err
);

  localparam int unsigned CW = $clog2(DEPTH+1);
  localparam logic [CW:0] C_DEPTH = (CW+1)'(DEPTH);

  logic            active_q;
  logic            held_q;
  logic [XLEN-1:0] held_addr_q;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
  logic [CW-1:0]   inflight_q, inflight_d;
  logic [CW-1:0]   discard_q, discard_d;
  logic            halted_q, halted_d;
  logic            held_stale_q, held_stale_d;

  logic            w_accept;
  logic            w_credit_ok;
  logic            w_rsp_keep;
  logic            w_pop;
  logic [CW-1:0]   w_count;
  logic [XLEN-1:0] w_redirect_aligned;
  fetch_entry_t    w_push_entry;
  fetch_entry_t    w_head;
  logic            w_unused;

  assign w_redirect_aligned = {redirect_pc[XLEN-1:2], 2'b00};
  assign w_unused           = &{1'b0, redirect_pc[1:0]};

  // A request already on the bus stays put (even across redirect) until accepted.
  assign w_credit_ok    = ({1'b0, inflight_q} + {1'b0, w_count}) < C_DEPTH;
  assign imem_req_valid = active_q & (held_q | (~halted_q & w_credit_ok & ~redirect_valid));
  assign imem_req_addr  = held_q ? held_addr_q : fetch_pc_q;
  assign w_accept       = imem_req_valid & imem_req_ready;

  assign w_rsp_keep = imem_rsp_valid & ~redirect_valid & (discard_q == '0);
  assign w_pop      = inst_valid & inst_ready;

  always_comb begin
    fetch_pc_d   = fetch_pc_q;
    rsp_pc_d     = rsp_pc_q;
    discard_d    = discard_q;
    halted_d     = halted_q;
    held_stale_d = held_stale_q;
    inflight_d   = inflight_q + CW'(w_accept) - CW'(imem_rsp_valid);
    if (redirect_valid) begin
      fetch_pc_d   = w_redirect_aligned;
      rsp_pc_d     = w_redirect_aligned;
      halted_d     = 1'b0;
      discard_d    = inflight_q + CW'(w_accept) - CW'(imem_rsp_valid);
      held_stale_d = held_q & ~imem_req_ready;
    end else begin
      // A stale held request was issued for the old stream; its accept adds a discard.
      if (w_accept) begin
        if (held_stale_q) held_stale_d = 1'b0;
        else              fetch_pc_d   = fetch_pc_q + XLEN'(4);
      end
      discard_d = discard_q + CW'(w_accept & held_stale_q)
                - CW'(imem_rsp_valid & (discard_q != '0));
      if (w_rsp_keep) begin
        rsp_pc_d = rsp_pc_q + XLEN'(4);
        if (imem_rsp_err) halted_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      active_q     <= 1'b0;
      held_q       <= 1'b0;
      held_addr_q  <= RESET_PC;
      fetch_pc_q   <= RESET_PC;
      rsp_pc_q     <= RESET_PC;
      inflight_q   <= '0;
      discard_q    <= '0;
      halted_q     <= 1'b0;
      held_stale_q <= 1'b0;
    end else begin
      active_q     <= 1'b1;
      held_q       <= imem_req_valid & ~imem_req_ready;
      held_addr_q  <= imem_req_addr;
      fetch_pc_q   <= fetch_pc_d;
      rsp_pc_q     <= rsp_pc_d;
      inflight_q   <= inflight_d;
      discard_q    <= discard_d;
      halted_q     <= halted_d;
      held_stale_q <= held_stale_d;
    end
  end

  assign w_push_entry = '{pc: rsp_pc_q, data: imem_rsp_data, err: imem_rsp_err};

  ysyx_23060203_fetch_fifo #(
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) u_fifo (
    .clk         (clk),
    .rstn        (rstn),
    .flush_i     (redirect_valid),
    .push_i      (w_rsp_keep),
    .push_data_i (w_push_entry),
    .pop_i       (w_pop),
    .head_o      (w_head),
    .count_o     (w_count)
  );

  assign inst_valid = (w_count != '0);
  assign inst_pc    = w_head.pc;
  assign inst_data  = w_head.data;
  assign inst_err   = w_head.err;

endmodule

`default_nettype wire

// File: tb/tb_ysyx_23060203_ifu_prefetch.sv
// ----------------------------------------------------------------------------
// tb_ysyx_23060203_ifu_prefetch : self-checking bench with memory model and scoreboard
// Revision: 1.0
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_ysyx_23060203_ifu_prefetch;

  localparam int          DEPTH = 4;
  localparam logic [31:0] RPC   = 32'h8000_0000;

  logic        clk;
  logic        rstn;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        imem_rsp_err;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_pc;
  logic [31:0] inst_data;
  logic        inst_err;

  ysyx_23060203_ifu_prefetch #(
    .XLEN     (32),
    .RESET_PC (RPC),
    .DEPTH    (DEPTH)
  ) dut (
    .clk            (clk),
    .rstn           (rstn),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .imem_rsp_err   (imem_rsp_err),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_pc        (inst_pc),
    .inst_data      (inst_data),
    .inst_err       (inst_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; int due; } mreq_t;
  typedef struct packed { logic [31:0] pc; logic [31:0] data; logic err; } exp_t;
  typedef struct {
    int mem_mode; int idu_mode; int lat;
    logic has_tgt; logic [31:0] tgt; int n; logic [31:0] last;
  } vec_t;

  mreq_t       memq[$];
  exp_t        expq[$];
  logic [31:0] acc_log[$];
  logic [31:0] cons_log[$];
  vec_t        vecs[5];

  int          checks, errors, cyc, last_due;
  int          mem_mode, idu_mode, lat_min, lat_max;
  logic        err_en;
  logic [31:0] err_addr, err_pc;
  logic        redir_req;
  logic [31:0] redir_tgt;
  logic        stall_prev;
  logic [31:0] sp_pc, sp_data;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], ~a[31:16]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fill(input logic [31:0] start, input int n);
    exp_t        e;
    logic [31:0] p;
    expq.delete();
    for (int i = 0; i < n; i++) begin
      p = start + 32'(4 * i);
      e.pc = p; e.data = memf(p); e.err = err_en && (p == err_addr);
      expq.push_back(e);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_req_valid"},  {31'b0, imem_req_valid}, 32'd0);
    chk({tag, "_req_addr"},   imem_req_addr, RPC);
    chk({tag, "_inst_valid"}, {31'b0, inst_valid}, 32'd0);
    chk({tag, "_inst_pc"},    inst_pc, RPC);
    chk({tag, "_inst_data"},  inst_data, 32'd0);
    chk({tag, "_inst_err"},   {31'b0, inst_err}, 32'd0);
  endtask

  // One clock: memory returns responses in order, handshakes are scored after settling.
  task automatic step();
    mreq_t m;
    exp_t  e;
    int    d;
    @(posedge clk); #1;
    cyc++;
    if (memq.size() > 0 && memq[0].due <= cyc) begin
      m = memq.pop_front();
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = memf(m.addr);
      imem_rsp_err   = err_en && (m.addr == err_addr);
    end else begin
      imem_rsp_valid = 1'b0; imem_rsp_data = 32'd0; imem_rsp_err = 1'b0;
    end
    imem_req_ready = (mem_mode == 0) ? 1'b1 : (mem_mode == 1) ? ($urandom_range(0, 1) == 1) : 1'b0;
    inst_ready     = (idu_mode == 0) ? 1'b1 : (idu_mode == 1) ? ($urandom_range(0, 2) != 0) : 1'b0;
    redirect_valid = redir_req;
    redirect_pc    = redir_tgt;
    #1;
    if (stall_prev && inst_valid) begin
      chk("hold_pc", inst_pc, sp_pc);
      chk("hold_data", inst_data, sp_data);
    end
    if (imem_req_valid && imem_req_ready) begin
      d = cyc + int'($urandom_range(lat_min, lat_max));
      if (d < last_due) d = last_due;
      last_due = d;
      m.addr = imem_req_addr; m.due = d;
      memq.push_back(m);
      acc_log.push_back(imem_req_addr);
    end
    if (inst_valid && inst_ready) begin
      if (expq.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_inst: got pc %h expected none", inst_pc);
      end else begin
        e = expq.pop_front();
        chk("inst_pc", inst_pc, e.pc);
        chk("inst_data", inst_data, e.data);
        chk("inst_err", {31'b0, inst_err}, {31'b0, e.err});
      end
      if (inst_err) err_pc = inst_pc;
      cons_log.push_back(inst_pc);
    end
    stall_prev = inst_valid && !inst_ready;
    sp_pc = inst_pc; sp_data = inst_data;
    if (redir_req) begin
      fill(redir_tgt & ~32'h3, 64);
      redir_req = 1'b0;
    end
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    redirect_valid = 1'b0; redir_req = 1'b0;
    imem_rsp_valid = 1'b0; imem_rsp_data = 32'd0; imem_rsp_err = 1'b0;
    memq.delete(); acc_log.delete(); cons_log.delete();
    last_due = 0; stall_prev = 1'b0;
    @(posedge clk); #1;
    chk_reset("rst");
    @(posedge clk); #1;
    rstn = 1'b1;
    fill(RPC, 64);
  endtask

  task automatic run_until(input int target, input int budget);
    int k;
    k = 0;
    while (cons_log.size() < target && k < budget) begin
      step();
      k++;
    end
    if (cons_log.size() < target) begin
      checks++; errors++;
      $display("FAIL timeout: consumed %0d expected %0d", cons_log.size(), target);
    end
  endtask

  initial begin
    int n0, k;
    vecs[0] = '{0, 0, 1, 1'b0, 32'h0,         12, 32'h8000_002C};
    vecs[1] = '{1, 0, 2, 1'b0, 32'h0,         10, 32'h8000_0024};
    vecs[2] = '{0, 1, 3, 1'b0, 32'h0,         10, 32'h8000_0024};
    vecs[3] = '{1, 1, 3, 1'b1, 32'h8000_0203,  8, 32'h8000_021C};
    vecs[4] = '{0, 0, 2, 1'b1, 32'hFFFF_FFF8,  4, 32'h0000_0004};

    checks = 0; errors = 0; cyc = 0;
    rstn = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0;
    imem_req_ready = 1'b0; inst_ready = 1'b0;
    imem_rsp_valid = 1'b0; imem_rsp_data = 32'd0; imem_rsp_err = 1'b0;
    err_en = 1'b0; err_addr = 32'd0; err_pc = 32'd0;
    redir_req = 1'b0; redir_tgt = 32'd0;
    mem_mode = 0; idu_mode = 0; lat_min = 1; lat_max = 1;

    // Test 1: reset values, first addresses, steady one instruction per cycle
    do_reset();
    step();
    chk("first_req_valid", {31'b0, imem_req_valid}, 32'd1);
    chk("first_req_addr", imem_req_addr, RPC);
    repeat (10) step();
    chk("addr0", acc_log[0], 32'h8000_0000);
    chk("addr1", acc_log[1], 32'h8000_0004);
    chk("addr2", acc_log[2], 32'h8000_0008);
    n0 = cons_log.size();
    repeat (10) step();
    chk("steady_rate", 32'(cons_log.size() - n0), 32'd10);

    // Table-driven streams: handshake patterns, latencies, misaligned and wrapping targets
    for (int v = 0; v < 5; v++) begin
      mem_mode = vecs[v].mem_mode; idu_mode = vecs[v].idu_mode;
      lat_min = 1; lat_max = vecs[v].lat;
      do_reset();
      if (vecs[v].has_tgt) begin
        redir_req = 1'b1; redir_tgt = vecs[v].tgt;
        step();
      end
      run_until(vecs[v].n, 400);
      chk("vec_count", 32'(cons_log.size()), 32'(vecs[v].n));
      if (cons_log.size() > 0) chk("vec_last_pc", cons_log[cons_log.size()-1], vecs[v].last);
    end

    // Test 2: consumer stalled -> DEPTH requests, then drain in order
    mem_mode = 0; idu_mode = 2; lat_min = 1; lat_max = 1;
    do_reset();
    repeat (10) step();
    chk("accepted_cap", 32'(acc_log.size()), 32'd4);
    chk("req_blocked", {31'b0, imem_req_valid}, 32'd0);
    chk("stall_head_valid", {31'b0, inst_valid}, 32'd1);
    chk("stall_head_pc", inst_pc, RPC);
    idu_mode = 0;
    run_until(4, 40);
    repeat (3) step();
    chk("req_resumed", {31'b0, acc_log.size() > 4}, 32'd1);

    // Test 3: redirect with three requests outstanding
    mem_mode = 0; idu_mode = 0; lat_min = 3; lat_max = 3;
    do_reset();
    k = 0;
    while (memq.size() < 3 && k < 20) begin step(); k++; end
    chk("three_outstanding", {31'b0, memq.size() >= 3}, 32'd1);
    redir_req = 1'b1; redir_tgt = 32'h8000_1000;
    step();
    step();
    chk("flush_empty", {31'b0, inst_valid}, 32'd0);
    n0 = cons_log.size();
    run_until(n0 + 4, 60);
    if (cons_log.size() > n0) chk("redir_first_pc", cons_log[n0], 32'h8000_1000);

    // Test 4: redirect while a request is held unaccepted
    mem_mode = 2; idu_mode = 0; lat_min = 1; lat_max = 1;
    do_reset();
    repeat (3) step();
    chk("held_valid", {31'b0, imem_req_valid}, 32'd1);
    redir_req = 1'b1; redir_tgt = 32'h8000_2000;
    step();
    chk("held_in_R_valid", {31'b0, imem_req_valid}, 32'd1);
    chk("held_in_R_addr", imem_req_addr, RPC);
    step();
    chk("held_after_R_addr", imem_req_addr, RPC);
    mem_mode = 0;
    n0 = acc_log.size();
    k = 0;
    while (acc_log.size() < n0 + 2 && k < 20) begin step(); k++; end
    chk("held_accept_count", {31'b0, acc_log.size() >= n0 + 2}, 32'd1);
    if (acc_log.size() >= n0 + 2) begin
      chk("stale_accept_addr", acc_log[n0], RPC);
      chk("new_stream_addr", acc_log[n0+1], 32'h8000_2000);
    end
    n0 = cons_log.size();
    run_until(n0 + 3, 40);
    if (cons_log.size() > n0) chk("held_first_pc", cons_log[n0], 32'h8000_2000);

    // Test 5: access fault halts fetch until a redirect
    err_en = 1'b1; err_addr = 32'h8000_0008; err_pc = 32'd0;
    mem_mode = 0; idu_mode = 0; lat_min = 1; lat_max = 1;
    do_reset();
    repeat (20) step();
    chk("err_pc", err_pc, 32'h8000_0008);
    n0 = acc_log.size();
    repeat (10) step();
    chk("halt_no_req", 32'(acc_log.size() - n0), 32'd0);
    chk("halt_req_valid", {31'b0, imem_req_valid}, 32'd0);
    redir_req = 1'b1; redir_tgt = 32'h8000_0100;
    step();
    n0 = cons_log.size();
    run_until(n0 + 4, 40);
    if (cons_log.size() > n0) chk("resume_pc", cons_log[n0], 32'h8000_0100);
    err_en = 1'b0;

    // Test 6: asynchronous reset mid-stream
    do_reset();
    repeat (8) step();
    @(posedge clk); #3;
    rstn = 1'b0;
    #1;
    chk_reset("async");
    redirect_valid = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_err = 1'b0;
    memq.delete(); cons_log.delete(); acc_log.delete();
    last_due = 0; stall_prev = 1'b0;
    fill(RPC, 64);
    @(posedge clk);
    @(posedge clk); #1;
    rstn = 1'b1;
    run_until(4, 40);
    if (cons_log.size() > 0) chk("restart_pc", cons_log[0], RPC);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
